// File: rtl/arith_pkg.sv
// arith_pkg: shared constants and FSM state type for the multi-cycle arithmetic blocks
package arith_pkg;
  localparam int DIV_W = 8;
  localparam int DIV_ITER = 8;
  localparam int DIV_CW = $clog2(DIV_ITER);
  localparam logic [DIV_W-1:0] DIV0_Q = 8'hFF;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} div_state_t;
endpackage

// File: rtl/subtract9.sv
// subtract9: 9-bit a - b as a + ~b + 1; ports a, b in; diff, carry_out (borrow = ~carry_out) out
module subtract9 (
  input  logic [8:0] a,
  input  logic [8:0] b,
  output logic [8:0] diff,
  output logic       carry_out
);
  assign {carry_out, diff} = {1'b0, a} + {1'b0, ~b} + 10'd1;
endmodule

// File: rtl/divider8_seq.sv
// divider8_seq: 8-bit restoring divider, one subtraction per clock; ports clk, rst, start/dividend/divisor in; busy, done, quotient, remainder, div_by_zero out
module divider8_seq
  import arith_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIV_W-1:0] dividend,
  input  logic [DIV_W-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [DIV_W-1:0] quotient,
  output logic [DIV_W-1:0] remainder,
  output logic             div_by_zero
);
  localparam logic [DIV_CW-1:0] CNT_LAST = DIV_CW'(DIV_ITER - 1);
  div_state_t        r_state;
  logic [DIV_W-1:0]  r_rem, r_q, r_d;
  logic [DIV_CW-1:0] r_cnt;
  logic [DIV_W:0]    w_shift, w_diff;
  logic              w_co, w_nb;
  logic [DIV_W-1:0]  w_rem_n, w_q_n;
  assign w_shift = {r_rem, r_q[DIV_W-1]};
  subtract9 u_sub (.a(w_shift), .b({1'b0, r_d}), .diff(w_diff), .carry_out(w_co));
  assign w_nb    = w_co & ~w_diff[DIV_W];
  assign w_rem_n = w_nb ? w_diff[DIV_W-1:0] : w_shift[DIV_W-1:0];
  assign w_q_n   = {r_q[DIV_W-2:0], w_nb};
  assign busy    = r_state == RUN;
  assign done    = r_state == DONE;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_rem       <= '0;
      r_q         <= '0;
      r_d         <= '0;
      r_cnt       <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (start) begin
          if (divisor == '0) begin
            quotient    <= DIV0_Q;
            remainder   <= dividend;
            div_by_zero <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_rem   <= '0;
            r_q     <= dividend;
            r_d     <= divisor;
            r_cnt   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_rem <= w_rem_n;
          r_q   <= w_q_n;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CNT_LAST) begin
            quotient    <= w_q_n;
            remainder   <= w_rem_n;
            div_by_zero <= 1'b0;
            r_state     <= DONE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_divider8_seq.sv
// tb_divider8_seq: directed and swept checks of divider8_seq against hand-computed results
module tb_divider8_seq;
  logic       clk, rst, start;
  logic [7:0] dividend, divisor;
  logic       busy, done, div_by_zero;
  logic [7:0] quotient, remainder;
  int n_chk, n_err;
  divider8_seq dut (
    .clk(clk), .rst(rst), .start(start), .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done), .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic check(input string tag, input int got, input int exp);
    n_chk++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic div_op(input logic [7:0] a, b, eq, er, input logic ez, input string tag);
    int n, nb;
    start = 1'b1; dividend = a; divisor = b;
    tick;
    start = 1'b0; dividend = 8'($urandom); divisor = 8'($urandom);
    n = 1; nb = 0;
    while (!done && n < 30) begin
      nb += int'(busy);
      tick;
      n++;
    end
    check({tag, " latency"}, n, ez ? 1 : 9);
    check({tag, " busy_cycles"}, nb, ez ? 0 : 8);
    check({tag, " quotient"}, quotient, eq);
    check({tag, " remainder"}, remainder, er);
    check({tag, " div_by_zero"}, div_by_zero, ez);
    tick;
    check({tag, " done_pulse_len"}, done, 0);
  endtask
  initial begin
    int n, seen_done;
    logic [7:0] a;
    n_chk = 0; n_err = 0;
    rst = 1'b1; start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    tick; tick;
    rst = 1'b0;
    check("rst busy", busy, 0);
    check("rst done", done, 0);
    check("rst quotient", quotient, 0);
    check("rst remainder", remainder, 0);
    check("rst dbz", div_by_zero, 0);
    div_op(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, "200/7");
    div_op(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, "255/1");
    div_op(8'd5, 8'd9, 8'd0, 8'd5, 1'b0, "5/9");
    div_op(8'd255, 8'd255, 8'd1, 8'd0, 1'b0, "255/255");
    div_op(8'd0, 8'd3, 8'd0, 8'd0, 1'b0, "0/3");
    div_op(8'd77, 8'd0, 8'hFF, 8'd77, 1'b1, "77/0");
    div_op(8'd10, 8'd3, 8'd3, 8'd1, 1'b0, "10/3");
    start = 1'b1; dividend = 8'd50; divisor = 8'd6;
    tick;
    for (int i = 1; i <= 8; i++) begin
      dividend = 8'(i * 17); divisor = 8'(i);
      tick;
    end
    check("hold done", done, 1);
    check("hold quotient", quotient, 8);
    check("hold remainder", remainder, 2);
    dividend = 8'd13; divisor = 8'd0;
    tick;
    check("hold idle busy", busy, 0);
    check("hold idle done", done, 0);
    dividend = 8'd90; divisor = 8'd7;
    tick;
    start = 1'b0; dividend = 8'd0; divisor = 8'd0;
    check("hold accept busy", busy, 1);
    n = 1;
    while (!done && n < 30) begin
      tick;
      n++;
    end
    check("hold2 latency", n, 9);
    check("hold2 quotient", quotient, 12);
    check("hold2 remainder", remainder, 6);
    check("hold2 dbz", div_by_zero, 0);
    tick;
    start = 1'b1; dividend = 8'd100; divisor = 8'd3;
    tick;
    start = 1'b0;
    tick; tick; tick;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    check("abort busy", busy, 0);
    check("abort done", done, 0);
    check("abort quotient", quotient, 0);
    check("abort remainder", remainder, 0);
    check("abort dbz", div_by_zero, 0);
    seen_done = 0;
    for (int i = 0; i < 12; i++) begin
      seen_done += int'(done) + int'(busy);
      tick;
    end
    check("abort quiet", seen_done, 0);
    div_op(8'd100, 8'd3, 8'd33, 8'd1, 1'b0, "100/3");
    rst = 1'b1; start = 1'b1; dividend = 8'd9; divisor = 8'd0;
    tick;
    rst = 1'b0; start = 1'b0;
    check("rst_start busy", busy, 0);
    check("rst_start done", done, 0);
    tick;
    check("rst_start done2", done, 0);
    check("rst_start dbz", div_by_zero, 0);
    for (int d = 1; d <= 255; d++) begin
      a = 8'($urandom_range(0, 255));
      div_op(a, 8'(d), 8'(a / 8'(d)), 8'(a % 8'(d)), 1'b0, "sweep");
      check("sweep identity", int'(quotient) * d + int'(remainder), int'(a));
      check("sweep rem_lt_div", int'(remainder < 8'(d)), 1);
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/divider8_seq.md
# divider8_seq

Sequential 8-bit unsigned restoring divider. It is the inverse companion to the team's 8-bit adder/subtractor datapath and reuses the same add-with-inverted-operand subtraction scheme. One subtraction is performed per clock over 8 iterations, and the block reports quotient, remainder and divide-by-zero. It sits beside the adder blocks as the multi-cycle arithmetic unit for the ALU, behind a simple start/done handshake.

## Interface
Parameters: none. Width is fixed at 8 bits.

Ports:
- clk  input  1  Single clock; all state updates on the rising edge.
- rst  input  1  Reset, synchronous, active-high.
- start  input  1  Request a division. Sampled only in IDLE.
- dividend  input  8  Unsigned dividend. Captured on the accepting edge.
- divisor  input  8  Unsigned divisor. Captured on the accepting edge.
- busy  output  1  High while in RUN.
- done  output  1  One-cycle pulse; results are valid from this cycle onward.
- quotient  output  8  Registered quotient.
- remainder  output  8  Registered remainder.
- div_by_zero  output  1  Registered; set with done when divisor was 0.

## Operation
- FSM states are IDLE, RUN and DONE. Decoded outputs: busy = (state==RUN), done = (state==DONE).
- IDLE:
  - start=1 and divisor!=0: load rem=9'd0, q=dividend, d=divisor, cnt=0, then go to RUN.
  - start=1 and divisor==0: load quotient=8'hFF, remainder=dividend, div_by_zero=1, then go to DONE. No iterations run.
  - start=0: stay in IDLE.
- RUN, one iteration per cycle:
  - trial = {rem[7:0], q[7]} − {1'b0, d}, computed as a + ~b + 1 on 9 bits.
  - No borrow (carry_out=1): rem=trial, q={q[6:0],1}.
  - Borrow: rem={rem[7:0],q[7]}, q={q[6:0],0}.
  - cnt increments each iteration. On the iteration with cnt==7, the final q and rem[7:0] load into quotient/remainder, div_by_zero=0, then go to DONE.
- DONE: held for exactly one cycle, then go to IDLE unconditionally.
- start is ignored in RUN and DONE. It is not queued.
- quotient, remainder and div_by_zero hold their values until the next completion or reset. dividend and divisor may change freely after the accepting edge.
- The remainder always fits in 8 bits. rem[8] is 0 at the end of every iteration.

## Timing
- Reset values: state=IDLE, busy=0, done=0, quotient=8'h00, remainder=8'h00, div_by_zero=0. Internal rem, q, d and cnt are cleared.
- Edge E0 is the edge where start is accepted in IDLE.
- Nonzero divisor:
  - busy=1 after E0 through E8, i.e. 8 cycles.
  - Iterations occur on E1..E8. Results register at E8.
  - done=1 in the cycle after E8, with busy=0 in that cycle.
  - IDLE is reached after E9. The earliest next accept is E10, so throughput is one division per 10 cycles.
- Zero divisor: done=1 in the cycle after E0, and busy is never asserted. The earliest next accept is E2.
- Reset has priority over everything. rst=1 at any edge, including mid-RUN or in DONE, aborts the operation, applies the reset values, and suppresses done.
- start and rst high on the same edge: reset wins and the request is dropped.

## Structure
- Shared package `arith_pkg` holds:
  - the FSM state enum (IDLE/RUN/DONE, 2-bit encoding),
  - the `DIV_W=8` and `DIV_ITER=8` constants,
  - the divide-by-zero quotient constant 8'hFF.
- One sub-module, `subtract9`: a 9-bit a − b built as a + ~b with carry_in=1. Its outputs are diff[8:0] and carry_out, where borrow = ~carry_out.
- The remaining logic (FSM, shift registers, counter, output registers) lives in `divider8_seq`.

## Test plan
- dividend=200, divisor=7 → quotient=28, remainder=4, div_by_zero=0. done pulses exactly 9 cycles after the accepting edge, and busy is high for exactly 8 cycles.
- Boundary values:
  - 255/1 → quotient=255, remainder=0.
  - 5/9 → quotient=0, remainder=5.
  - 255/255 → quotient=1, remainder=0.
  - 0/3 → quotient=0, remainder=0.
- 77/0 → done in the cycle after the accepting edge, quotient=8'hFF, remainder=77, div_by_zero=1, busy never high. A following 10/3 clears div_by_zero and gives quotient=3, remainder=1.
- Hold start high continuously with a new operand pair each cycle → only IDLE-sampled requests execute. start during RUN and DONE is ignored, and the accepted operands are not corrupted by input changes mid-RUN.
- Assert rst at iteration 4 of 100/3 → no done pulse, all outputs return to reset values. A subsequent 100/3 gives quotient=33, remainder=1.
- Randomised sweep of all divisor values 1..255 against a reference model → quotient*divisor+remainder==dividend and remainder<divisor in every case.
